// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs request fields into a 32-bit word and queues it in a 4-deep FIFO.
// Optional ENCODER_EXT_ISA_EN enables classes 9-14 (ADDIU, ANDI, LUI, SLTI, SLTIU, XORI); otherwise they are illegal.
module instr_encoder (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic        InValid,
   output logic        InReady,
   input  logic [3:0]  InstClass,
   input  logic [4:0]  Rs,
   input  logic [4:0]  Rt,
   input  logic [4:0]  Rd,
   input  logic [4:0]  Shamt,
   input  logic [5:0]  FuncCode,
   input  logic [15:0] Imm16,
   input  logic [25:0] Target,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] Instr,
   output logic        ErrPulse,
   output logic [7:0]  ErrCount,
   output logic [15:0] InstCount
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef ENCODER_EXT_ISA_EN
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_XORI  = 6'b001110;
`endif
   localparam logic [5:0] FN_JR    = 6'b001000;

   logic [31:0] fifoMem [0:3];
   logic [1:0]  wrPtr;
   logic [1:0]  rdPtr;
   logic [2:0]  fifoCount;
   logic [31:0] encWord;
   logic        encLegal;
   logic        accept;
   logic        doPush;
   logic        doPop;

   always_comb begin
      encWord  = '0;
      encLegal = 1'b1;
      case (InstClass)
         4'd0: begin
            if (FuncCode == FN_JR)
               encWord = {OP_RTYPE, Rs, 5'd0, 5'd0, 5'd0, FuncCode};
            else
               encWord = {OP_RTYPE, Rs, Rt, Rd, Shamt, FuncCode};
         end
         4'd1:  encWord = {OP_LW,   Rs, Rt, Imm16};
         4'd2:  encWord = {OP_SW,   Rs, Rt, Imm16};
         4'd3:  encWord = {OP_BEQ,  Rs, Rt, Imm16};
         4'd4:  encWord = {OP_BNE,  Rs, Rt, Imm16};
         4'd5:  encWord = {OP_J,    Target};
         4'd6:  encWord = {OP_JAL,  Target};
         4'd7:  encWord = {OP_ORI,  Rs, Rt, Imm16};
         4'd8:  encWord = {OP_ADDI, Rs, Rt, Imm16};
`ifdef ENCODER_EXT_ISA_EN
         4'd9:  encWord = {OP_ADDIU, Rs, Rt, Imm16};
         4'd10: encWord = {OP_ANDI,  Rs, Rt, Imm16};
         4'd11: encWord = {OP_LUI,   5'd0, Rt, Imm16};
         4'd12: encWord = {OP_SLTI,  Rs, Rt, Imm16};
         4'd13: encWord = {OP_SLTIU, Rs, Rt, Imm16};
         4'd14: encWord = {OP_XORI,  Rs, Rt, Imm16};
`endif
         default: encLegal = 1'b0;
      endcase
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // ready depends only on registered occupancy, never on the same-cycle valid.
   assign InReady  = (fifoCount != 3'd4);
   assign OutValid = (fifoCount != 3'd0);
   assign Instr    = OutValid ? fifoMem[rdPtr] : 32'd0;

   assign accept = InValid && InReady;
   assign doPush = accept && encLegal;
   assign doPop  = OutValid && OutReady;

   // Storage is not reset: Instr is gated by OutValid, so stale contents never leak out.
   always_ff @(posedge CLK) begin
      if (doPush)
         fifoMem[wrPtr] <= encWord;
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         ErrPulse  <= 1'b0;
         ErrCount  <= '0;
         InstCount <= '0;
      end else begin
         if (doPush)
            wrPtr <= wrPtr + 2'd1;
         if (doPop) begin
            rdPtr     <= rdPtr + 2'd1;
            InstCount <= InstCount + 16'd1;
         end
         case ({doPush, doPop})
            2'b10:   fifoCount <= fifoCount + 3'd1;
            2'b01:   fifoCount <= fifoCount - 3'd1;
            default: fifoCount <= fifoCount;
         endcase
         ErrPulse <= accept && !encLegal;
         if (accept && !encLegal && (ErrCount != 8'hFF))
            ErrCount <= ErrCount + 8'd1;
      end
   end

endmodule
